// File: rtl/rect_fill_plotter.sv
// Rectangle fill pixel streamer feeding the VGA adapter: one clipped, row-major plot per unstalled cycle.
// Optional perimeter-only drawing is compiled in with `define OUTLINE_MODE_EN (adds the outline input).
module rect_fill_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     width,
  input  logic [Y_W-1:0]     height,
  input  logic [COLOR_W-1:0] colour,
`ifdef OUTLINE_MODE_EN
  input  logic               outline,
`endif
  input  logic               stall,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] colour_out,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  // Handshake: plot acts as valid and ~stall as ready; a pixel transfers on a
  // rising edge where plot=1 and stall=0, otherwise the request is held as-is.

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t               state_q, state_d;
  logic [X_W-1:0]       x0_q, x0_d, x_end_q, x_end_d, x_d;
  logic [Y_W-1:0]       y0_q, y0_d, y_end_q, y_end_d, y_d;
  logic [COLOR_W-1:0]   colour_d;
  logic                 outline_q, outline_d, outline_cmd;
  logic                 plot_d, busy_d, done_d;

  logic [X_W:0]         x_sum, x_lim, x_lim_m1;
  logic [Y_W:0]         y_sum, y_lim, y_lim_m1;
  logic                 empty_cmd, interior_row;

`ifdef OUTLINE_MODE_EN
  assign outline_cmd = outline;
`else
  assign outline_cmd = 1'b0;
`endif

  // Clipped inclusive bounds, computed one bit wider so x0+width cannot wrap.
  always_comb begin
    x_sum     = {1'b0, x0} + {1'b0, width};
    y_sum     = {1'b0, y0} + {1'b0, height};
    x_lim     = (x_sum > SCR_W) ? SCR_W : x_sum;
    y_lim     = (y_sum > SCR_H) ? SCR_H : y_sum;
    x_lim_m1  = x_lim - (X_W+1)'(1);
    y_lim_m1  = y_lim - (Y_W+1)'(1);
    empty_cmd = (width == '0) || (height == '0) ||
                ({1'b0, x0} >= SCR_W) || ({1'b0, y0} >= SCR_H);
  end

  assign interior_row = outline_q && (y_out != y0_q) && (y_out != y_end_q);

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    x_end_d   = x_end_q;
    y_end_d   = y_end_q;
    outline_d = outline_q;
    x_d       = x_out;
    y_d       = y_out;
    colour_d  = colour_out;
    plot_d    = plot;
    busy_d    = busy;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d      = x0;
          y0_d      = y0;
          x_end_d   = x_lim_m1[X_W-1:0];
          y_end_d   = y_lim_m1[Y_W-1:0];
          outline_d = outline_cmd;
          colour_d  = colour;
          if (empty_cmd) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAW;
            x_d     = x0;
            y_d     = y0;
            plot_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      DRAW: begin
        if (!stall) begin
          if ((x_out == x_end_q) && (y_out == y_end_q)) begin
            state_d = DONE;
            plot_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (x_out < x_end_q) begin
            // Interior outline rows skip straight from the left edge to the right edge.
            if (interior_row && (x_out == x0_q)) x_d = x_end_q;
            else                                 x_d = x_out + X_W'(1);
          end else begin
            x_d = x0_q;
            y_d = y_out + Y_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        plot_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      outline_q  <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      outline_q  <= outline_d;
      x_out      <= x_d;
      y_out      <= y_d;
      colour_out <= colour_d;
      plot       <= plot_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_rect_fill_plotter.sv
// Self-checking bench for rect_fill_plotter: reference pixel list built from the rectangle/clipping rules,
// consumed as pixels are accepted under directed and random stall patterns.
module tb_rect_fill_plotter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] x0, width;
  logic [6:0] y0, height;
  logic [2:0] colour;
  logic       outline;
  logic       stall;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  int checks   = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  rect_fill_plotter dut (
    .CLOCK_50  (clk),
    .Reset     (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .width     (width),
    .height    (height),
    .colour    (colour),
`ifdef OUTLINE_MODE_EN
    .outline   (outline),
`endif
    .stall     (stall),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour_out(colour_out),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pixels: every visible (x,y) of the rectangle in row-major order,
  // keeping only perimeter pixels of the clipped rectangle for outline commands.
  task automatic build_model(input int ax0, input int ay0, input int aw, input int ah,
                             input logic [2:0] col, input logic ol);
    int xe, ye;
    exp_q.delete();
    xe = ((ax0 + aw) < 160 ? (ax0 + aw) : 160) - 1;
    ye = ((ay0 + ah) < 120 ? (ay0 + ah) : 120) - 1;
    for (int y = ay0; y <= ye; y++)
      for (int x = ax0; x <= xe; x++)
        if (!ol || y == ay0 || y == ye || x == ax0 || x == xe)
          exp_q.push_back({8'(x), 7'(y), col});
  endtask

  // stall_mode: 0 none, 1 random, 2 three stall cycles on the second pixel.
  task automatic run_cmd(input string name, input int ax0, input int ay0, input int aw, input int ah,
                         input logic [2:0] col, input logic ol, input int stall_mode, input bit poke);
    int cyc, stalls, npix, accepted, stall_left, first_cyc;
    bit seen_done;
    @(negedge clk);
    x0 = 8'(ax0); y0 = 7'(ay0); width = 8'(aw); height = 7'(ah);
    colour = col; outline = ol; stall = 1'b0; start = 1'b1;
    build_model(ax0, ay0, aw, ah, col, ol);
    npix = exp_q.size();
    cyc = 0; stalls = 0; accepted = 0; stall_left = 3; first_cyc = 0; seen_done = 0;
    while (!seen_done && cyc < 600) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (plot) begin
        if (first_cyc == 0) first_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_plot: got (%0d,%0d) required no plot", name, x_out, y_out);
        end else if ({x_out, y_out, colour_out} !== exp_q[0]) begin
          failures++;
          $display("FAIL %s pixel: got (%0d,%0d,%b) required (%0d,%0d,%b)", name, x_out, y_out,
                   colour_out, exp_q[0][17:10], exp_q[0][9:3], exp_q[0][2:0]);
        end
        checks++;
        if (busy !== 1'b1 || x_out >= 8'd160 || y_out >= 7'd120) begin
          failures++;
          $display("FAIL %s busy_bounds: got busy=%b (%0d,%0d) required busy=1 on screen", name, busy, x_out, y_out);
        end
      end
      if (done) begin
        seen_done = 1;
        checks++;
        if (exp_q.size() != 0 || cyc != npix + stalls + 1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL %s done: got cyc=%0d left=%0d busy=%b required cyc=%0d left=0 busy=0",
                   name, cyc, exp_q.size(), busy, npix + stalls + 1);
        end
      end
      // Drive stall for the coming edge, then account for acceptance at that edge.
      case (stall_mode)
        1:       stall = ($urandom_range(99) < 30);
        2:       stall = (plot && accepted == 1 && stall_left > 0);
        default: stall = 1'b0;
      endcase
      if (stall_mode == 2 && stall) stall_left--;
      if (poke && plot && accepted == 2) begin
        start = 1'b1;
        x0 = 8'($urandom_range(159)); y0 = 7'($urandom_range(119));
        width = 8'($urandom_range(1, 20)); height = 7'($urandom_range(1, 20));
        colour = 3'($urandom_range(7));
      end
      if (plot && !stall && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        accepted++;
      end else if (plot) begin
        stalls++;
      end
    end
    if (!seen_done) begin
      checks++; failures++;
      $display("FAIL %s timeout: got no done required done within 600 cycles", name);
    end
    if (npix > 0) begin
      checks++;
      if (first_cyc != 1) begin
        failures++;
        $display("FAIL %s first_plot: got cycle %0d required cycle 1", name, first_cyc);
      end
    end
    if (stall_mode == 2) begin
      checks++;
      if (stalls != 3) begin
        failures++;
        $display("FAIL %s stall_hold: got %0d held cycles required 3", name, stalls);
      end
    end
    @(negedge clk);
    start = 1'b0; stall = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: got done=%b busy=%b plot=%b required 0 0 0", name, done, busy, plot);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; outline = 1'b0;
    x0 = 8'd0; y0 = 7'd0; width = 8'd0; height = 7'd0; colour = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({x_out, y_out, colour_out, plot, busy, done} !== 21'd0) begin
      failures++;
      $display("FAIL reset: got x=%0d y=%0d c=%b plot=%b busy=%b done=%b required all 0",
               x_out, y_out, colour_out, plot, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    run_cmd("single", 4, 4, 1, 1, 3'b100, 1'b0, 0, 1'b0);
    run_cmd("fill_3x2", 10, 20, 3, 2, 3'b011, 1'b0, 0, 1'b0);
    run_cmd("clip_corner", 158, 118, 5, 5, 3'b010, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_cmd("stall_3x2", 10, 20, 3, 2, 3'b101, 1'b0, 2, 1'b0);
  endtask

  task automatic test_empty();
    run_cmd("empty_w0", 10, 10, 0, 5, 3'b001, 1'b0, 0, 1'b0);
    run_cmd("empty_h0", 10, 10, 4, 0, 3'b001, 1'b0, 0, 1'b0);
    run_cmd("empty_offx", 200, 10, 4, 4, 3'b001, 1'b0, 0, 1'b0);
    run_cmd("empty_offy", 10, 120, 4, 4, 3'b001, 1'b0, 1, 1'b0);
  endtask

  task automatic test_busy_start();
    run_cmd("busy_start", 10, 20, 3, 2, 3'b110, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_draw();
    int plots;
    @(negedge clk);
    x0 = 8'd10; y0 = 7'd20; width = 8'd3; height = 7'd2; colour = 3'b111; outline = 1'b0;
    stall = 1'b0; start = 1'b1;
    plots = 0;
    for (int i = 0; i < 20 && plots < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (plot) plots++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || plots != 3) begin
      failures++;
      $display("FAIL mid_reset: got plot=%b busy=%b done=%b plots=%0d required 0 0 0 3", plot, busy, done, plots);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || plot !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_quiet: got done=%b plot=%b required 0 0", done, plot);
      end
    end
    run_cmd("post_reset_1x1", 50, 60, 1, 1, 3'b100, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int ax, ay;
      ax = ($urandom_range(9) == 0) ? $urandom_range(150, 200) : $urandom_range(159);
      ay = ($urandom_range(9) == 0) ? $urandom_range(110, 127) : $urandom_range(119);
      run_cmd("random", ax, ay, $urandom_range(0, 12), $urandom_range(0, 10),
              3'($urandom_range(7)), 1'b0, 1, 1'b0);
    end
  endtask

`ifdef OUTLINE_MODE_EN
  task automatic test_outline();
    run_cmd("outline_4x3", 0, 0, 4, 3, 3'b010, 1'b1, 0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL outline_residue: got %0d pixels left required 0", exp_q.size());
    end
    run_cmd("outline_clip1", 159, 5, 6, 4, 3'b011, 1'b1, 1, 1'b0);
    for (int n = 0; n < 10; n++)
      run_cmd("outline_rand", $urandom_range(159), $urandom_range(119), $urandom_range(0, 10),
              $urandom_range(0, 8), 3'($urandom_range(7)), 1'b1, 1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_empty();
    test_busy_start();
    test_reset_mid_draw();
    test_random();
`ifdef OUTLINE_MODE_EN
    test_outline();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
